keypad_ctrl: RTL and testbench
==============================

Name: keypad_ctrl

Overview:
- Sequencer and CPU-side arbiter for the 4x4 hex keypad matrix.
- Drives the column scan with a programmable dwell time and debounces all 16 keys.
- Serves CHIP-8 key instructions over a valid/ready command/response handshake: key query (EX9E/EXA1) and blocking wait-for-key (FX0A).
- Sits between the keypad pins and the CPU core; replaces free-running per-clock scanning.

Parameters:
- SETTLE_CYCLES, 1000: clock cycles each column stays driven low before row_pins is sampled (≥1).
- DEBOUNCE_SCANS, 4: consecutive full scans a raw key level must differ from its debounced level before the debounced level flips (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- column_pins  out  4  one-hot-low column drive
- row_pins  in  4  row sense, active-low (0 = pressed)
- keys  out  16  debounced key levels, bit k = key k
- any_key  out  1  OR of keys
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller accepts a command
- cmd_op  in  2  00 = query, 01 = wait_key, 1x = reserved
- cmd_key  in  4  key index for query
- cmd_abort  in  1  cancel an in-progress wait_key
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_key  out  4  key index of response
- rsp_pressed  out  1  query result; 1 for wait_key responses

Behaviour:
- Reset values:
  - column_pins = 4'b1110; dwell counter = 0; column = 0.
  - keys = 0; all debounce counters = 0.
  - FSM = IDLE; rsp_valid = 0; rsp_key = 0; rsp_pressed = 0.
- Reset asserted mid-operation discards any pending command or response; no response is issued.
- Scan:
  - Column c is driven for exactly SETTLE_CYCLES cycles.
  - On the last dwell cycle, raw[i*4+c] = !row_pins[i] for i = 0..3.
  - column_pins then rotates left (1110 → 1101 → 1011 → 0111 → 1110) and c increments mod 4.
  - One full scan = 4*SETTLE_CYCLES cycles; a scan completes when column 3 is sampled.
- Debounce, per key, evaluated at scan completion:
  - If raw ≠ keys[k], counter increments; else counter clears.
  - When counter reaches DEBOUNCE_SCANS, keys[k] toggles and counter clears.
  - keys changes only on scan-completion cycles.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, RESPOND.
- cmd_ready = 1 only in IDLE with rsp_valid = 0. A command is accepted when cmd_valid && cmd_ready.
- Query (00): next cycle → RESPOND with rsp_valid = 1, rsp_key = cmd_key, rsp_pressed = keys[cmd_key] as of the accept cycle. Latency 1.
- Reserved op (1x): next cycle → RESPOND with rsp_key = cmd_key, rsp_pressed = 0.
- wait_key (01):
  - Accept → WAIT_PRESS. A snapshot of keys is taken at accept.
  - Only a debounced 0→1 edge after accept qualifies; keys already held at accept are ignored until released and re-pressed.
  - On a qualifying edge, latch the lowest-index rising key → WAIT_RELEASE.
  - When keys[latched] = 0 → RESPOND with rsp_key = latched, rsp_pressed = 1.
  - Other keys changing while in WAIT_RELEASE are ignored.
- cmd_abort in WAIT_PRESS or WAIT_RELEASE: → IDLE next cycle, no response. Ignored in IDLE and RESPOND.
- RESPOND: rsp_valid held with stable rsp_key/rsp_pressed until rsp_ready; the handshake cycle returns the FSM to IDLE. A new command can be accepted the cycle after.
- Simultaneous rising edges within one scan: lowest index wins.
- Scanning and debounce run continuously, independent of FSM state.

Optional Feature:
- Macro KEYPAD_WAIT_RELEASE_EN.
- Defined: wait_key completes on release, as above.
- Undefined: WAIT_RELEASE is removed; wait_key → RESPOND one cycle after the qualifying rising edge.

Test Plan:
- SETTLE_CYCLES=2, DEBOUNCE_SCANS=2, no keys, reset release → column_pins sequence 1110,1110,1101,1101,1011,1011,0111,0111,1110; keys = 0, any_key = 0.
- Hold row_pins[1] = 0 while column 2 is driven, every scan → keys[6] = 1 exactly at completion of the 2nd full scan (cycle 16 after reset); bounce a single scan instead → keys stays 0.
- keys[6] = 1, query cmd_key = 6 → rsp_valid next cycle, rsp_key = 6, rsp_pressed = 1; query key 7 → rsp_pressed = 0; hold rsp_ready = 0 for 5 cycles → response stable, cmd_ready = 0.
- Key 5 held at accept, wait_key, then press key 10, release key 10 → no response while 5 held; rsp_key = 10 after keys[10] falls; rsp_key = 5 only after 5 is released and re-pressed on a fresh command.
- Keys 3 and 12 debounce high on the same scan during WAIT_PRESS → latched key 3; with KEYPAD_WAIT_RELEASE_EN undefined, rsp_valid one cycle after that scan completes.
- cmd_abort in WAIT_PRESS → IDLE next cycle, no rsp_valid; rst asserted in WAIT_RELEASE → all outputs at reset values next cycle, column_pins = 1110.

Source files
------------

// File: rtl/keypad_ctrl.sv
// keypad_ctrl: 4x4 keypad column scanner, per-key debouncer and CHIP-8 key command server.
// Define KEYPAD_WAIT_RELEASE_EN to make wait_key complete on release instead of on press.
module keypad_ctrl #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  column_pins,
  input  logic [3:0]  row_pins,
  output logic [15:0] keys,
  output logic        any_key,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_key,
  input  logic        cmd_abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_key,
  output logic        rsp_pressed
);
  localparam int DW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);

`ifdef KEYPAD_WAIT_RELEASE_EN
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, RESPOND} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, RESPOND} state_t;
`endif

  state_t state, state_next;
  logic [DW-1:0] dwell;
  logic [1:0] col;
  logic [15:0] raw, raw_next, armed, rise;
  logic [3:0] first;
  logic last, done, accept;

  assign last = dwell == DW'(SETTLE_CYCLES - 1);
  assign done = last && col == 2'd3;
  assign column_pins = ~(4'b0001 << col);
  assign any_key = |keys;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESPOND;
  assign accept = cmd_valid && cmd_ready;
  assign rise = keys & armed;

  // raw_next folds the column being sampled this cycle into the scan image
  always_comb begin
    raw_next = raw;
    for (int i = 0; i < 4; i++) raw_next[{2'(i), col}] = ~row_pins[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
      col <= '0;
      raw <= '0;
    end else begin
      dwell <= last ? '0 : dwell + DW'(1);
      if (last) begin
        col <= col + 2'd1;
        raw <= raw_next;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_db
    logic [BW-1:0] cnt;
    logic key;
    assign keys[g] = key;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        key <= 1'b0;
      end else if (done) begin
        if (raw_next[g] == key) cnt <= '0;
        else if (cnt + BW'(1) == BW'(DEBOUNCE_SCANS)) begin
          cnt <= '0;
          key <= ~key;
        end else cnt <= cnt + BW'(1);
      end
    end
  end

  always_comb begin
    first = '0;
    for (int k = 15; k >= 0; k--) if (rise[k]) first = 4'(k);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = cmd_op == 2'b01 ? WAIT_PRESS : RESPOND;
`ifdef KEYPAD_WAIT_RELEASE_EN
      WAIT_PRESS: state_next = cmd_abort ? IDLE : |rise ? WAIT_RELEASE : WAIT_PRESS;
      WAIT_RELEASE: state_next = cmd_abort ? IDLE : !keys[rsp_key] ? RESPOND : WAIT_RELEASE;
`else
      WAIT_PRESS: state_next = cmd_abort ? IDLE : |rise ? RESPOND : WAIT_PRESS;
`endif
      RESPOND: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // armed marks keys seen released since accept; only those may produce a qualifying press
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= '0;
      rsp_key <= '0;
      rsp_pressed <= 1'b0;
    end else if (accept) begin
      armed <= ~keys;
      rsp_key <= cmd_key;
      rsp_pressed <= cmd_op == 2'b00 && keys[cmd_key];
    end else if (state == WAIT_PRESS) begin
      armed <= armed | ~keys;
      if (|rise) begin
        rsp_key <= first;
        rsp_pressed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_keypad_ctrl.sv
// tb_keypad_ctrl: random and directed stimulus against a cycle-level behavioural keypad model.
module tb_keypad_ctrl;
  localparam int S = 2, D = 2;
`ifdef KEYPAD_WAIT_RELEASE_EN
  localparam bit REL = 1;
`else
  localparam bit REL = 0;
`endif
  logic clk = 0, rst = 1;
  logic [3:0] column_pins, row_pins;
  logic [15:0] keys, pressed = 0;
  logic any_key, cmd_valid = 0, cmd_ready, cmd_abort = 0, rsp_valid, rsp_ready = 0, rsp_pressed;
  logic [1:0] cmd_op = 0;
  logic [3:0] cmd_key = 0, rsp_key;
  int total = 0, bad = 0;
  int mt = 0, ms = 0, mrk = 0, streak[16];
  logic mrp = 0, macc = 0;
  logic [15:0] mkeys = 0, mraw = 0, blocked = 0;

  keypad_ctrl #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst(rst), .column_pins(column_pins), .row_pins(row_pins), .keys(keys),
    .any_key(any_key), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_abort(cmd_abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_key(rsp_key), .rsp_pressed(rsp_pressed)
  );

  always #5 clk = ~clk;

  // physical matrix: a row reads low when a pressed key sits on a driven-low column
  always_comb
    for (int i = 0; i < 4; i++) row_pins[i] = ~|(pressed[i*4 +: 4] & ~column_pins);

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lowest(logic [15:0] v);
    for (int k = 0; k < 16; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic step();
    logic [15:0] q;
    int c;
    bit was_rst;
    @(posedge clk);
    macc = 0;
    was_rst = rst;
    if (rst) begin
      mt = 0; ms = 0; mrk = 0; mrp = 0; mkeys = 0; mraw = 0; blocked = 0;
      for (int k = 0; k < 16; k++) streak[k] = 0;
    end else begin
      case (ms)
        0: if (cmd_valid) begin
             macc = 1;
             mrk = cmd_key;
             if (cmd_op == 1) begin ms = 1; blocked = mkeys; end
             else begin ms = 3; mrp = cmd_op == 0 && mkeys[cmd_key]; end
           end
        1: if (cmd_abort) ms = 0;
           else begin
             q = mkeys & ~blocked;
             if (q != 0) begin mrk = lowest(q); mrp = 1; ms = REL ? 2 : 3; end
             blocked &= mkeys;
           end
        2: if (cmd_abort) ms = 0; else if (!mkeys[mrk]) ms = 3;
        default: if (rsp_ready) ms = 0;
      endcase
      c = (mt / S) % 4;
      if (mt % S == S - 1) begin
        for (int i = 0; i < 4; i++) mraw[i*4 + c] = pressed[i*4 + c];
        if (c == 3)
          for (int k = 0; k < 16; k++)
            if (mraw[k] != mkeys[k]) begin
              streak[k]++;
              if (streak[k] == D) begin mkeys[k] = ~mkeys[k]; streak[k] = 0; end
            end else streak[k] = 0;
      end
      mt++;
    end
    @(negedge clk);
    chk("col", column_pins, 4'hF ^ (4'h1 << ((mt / S) % 4)));
    chk("keys", keys, mkeys);
    chk("any", any_key, |mkeys);
    chk("ready", cmd_ready, ms == 0);
    chk("rvalid", rsp_valid, ms == 3);
    if (was_rst || ms == 3) begin
      chk("rkey", rsp_key, mrk[3:0]);
      chk("rpress", rsp_pressed, mrp);
    end
  endtask

  task automatic align();
    while (mt % (4 * S) != 0) step();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] key);
    cmd_valid = 1; cmd_op = op; cmd_key = key;
    for (int n = 0; n < 50 && !macc; n++) step();
    cmd_valid = 0;
    chk("accept", macc, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("rsp_taken", rsp_valid, 0);
  endtask

  task automatic wait_rsp(input logic [3:0] exp);
    for (int n = 0; n < 100 && ms != 3; n++) step();
    chk("wait_rvalid", rsp_valid, 1);
    chk("wait_rkey", rsp_key, exp);
    chk("wait_rpress", rsp_pressed, 1);
  endtask

  initial begin
    int r;
    repeat (3) step();
    pressed = 16'h0040;
    rst = 0;
    repeat (15) step();
    chk("k6_early", keys[6], 0);
    step();
    chk("k6_up", keys[6], 1);
    align();
    pressed[9] = 1;
    repeat (8) step();
    pressed[9] = 0;
    repeat (16) step();
    chk("bounce9", keys[9], 0);
    send_cmd(0, 6);
    chk("q6_valid", rsp_valid, 1);
    chk("q6_key", rsp_key, 6);
    chk("q6_press", rsp_pressed, 1);
    repeat (5) step();
    chk("q6_hold_key", rsp_key, 6);
    chk("q6_hold_ready", cmd_ready, 0);
    take_rsp();
    send_cmd(0, 7);
    chk("q7_press", rsp_pressed, 0);
    take_rsp();
    send_cmd(2, 6);
    chk("resv_press", rsp_pressed, 0);
    take_rsp();
    pressed = 16'h0020;
    repeat (24) step();
    chk("k5_up", keys[5], 1);
    send_cmd(1, 0);
    repeat (30) step();
    chk("held5_norsp", rsp_valid, 0);
    pressed[10] = 1;
    repeat (24) step();
    pressed[10] = 0;
    wait_rsp(10);
    take_rsp();
    send_cmd(1, 0);
    pressed[5] = 0;
    repeat (24) step();
    chk("rel5_norsp", rsp_valid, 0);
    pressed[5] = 1;
    repeat (24) step();
    pressed[5] = 0;
    wait_rsp(5);
    take_rsp();
    repeat (24) step();
    send_cmd(1, 0);
    align();
    pressed = 16'h1008;
    repeat (24) step();
    pressed = 0;
    wait_rsp(3);
    take_rsp();
    repeat (24) step();
    send_cmd(1, 0);
    repeat (3) step();
    cmd_abort = 1;
    step();
    cmd_abort = 0;
    chk("abort_ready", cmd_ready, 1);
    chk("abort_valid", rsp_valid, 0);
    send_cmd(1, 0);
    pressed[1] = 1;
    repeat (24) step();
    rst = 1;
    step();
    rst = 0;
    pressed = 0;
    chk("rst_col", column_pins, 4'b1110);
    chk("rst_keys", keys, 0);
    chk("rst_valid", rsp_valid, 0);
    for (int n = 0; n < 3000; n++) begin
      cmd_valid = $urandom_range(3) == 0;
      cmd_op = 2'($urandom);
      cmd_key = 4'($urandom);
      cmd_abort = $urandom_range(15) == 0;
      rsp_ready = 1'($urandom_range(1));
      r = $urandom_range(15);
      if ($urandom_range(29) == 0) pressed[r] = ~pressed[r];
      rst = $urandom_range(999) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
